// File: rtl/eth_rr_select.sv
// Combinational round-robin priority encoder.
// Picks the first asserted request searching cyclically from last_idx + 1,
// so the most recently served requester has the lowest priority.
module eth_rr_select #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last_idx,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             vld
);

    logic [IDX_W-1:0] cand;

    // Walk the requesters starting just after the last winner; the first hit wins.
    always_comb begin
        gnt  = '0;
        idx  = '0;
        vld  = 1'b0;
        cand = '0;
        for (int k = 1; k <= N; k++) begin
            cand = IDX_W'((int'(last_idx) + k) % N);
            if (!vld && req[cand]) begin
                vld       = 1'b1;
                idx       = cand;
                gnt[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/eth_tx_axis_arbiter.sv
// Frame-atomic round-robin arbiter in front of the 1G MAC transmit AXI-Stream.
// The owner keeps the link until its tlast beat; frames that reach MAX_LEN
// beats without tlast are cut (tlast+tuser forced) and the rest is flushed.
module eth_tx_axis_arbiter #(
    parameter int N_SRC   = 4,
    parameter int MAX_LEN = 2048,
    parameter int LEN_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [8*N_SRC-1:0]   s_axis_tdata,
    input  logic [N_SRC-1:0]     s_axis_tvalid,
    output logic [N_SRC-1:0]     s_axis_tready,
    input  logic [N_SRC-1:0]     s_axis_tlast,
    input  logic [N_SRC-1:0]     s_axis_tuser,
    output logic [7:0]           m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 m_axis_tlast,
    output logic                 m_axis_tuser,
    output logic [N_SRC-1:0]     grant,
    output logic                 busy,
    output logic                 oversize
);

    localparam int IDX_W = $clog2(N_SRC);
    localparam logic [LEN_W-1:0] LAST_BEAT = LEN_W'(MAX_LEN - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [N_SRC-1:0] grant_q;
    logic [IDX_W-1:0] sel_q;      // index of the current (or most recent) owner
    logic [LEN_W-1:0] beat_cnt;
    logic             oversize_q;

    logic [N_SRC-1:0] rr_gnt;
    logic [IDX_W-1:0] rr_idx;
    logic             rr_vld;

    logic [7:0] src_tdata;
    logic       src_valid;
    logic       src_last;
    logic       src_user;
    logic       trunc;

    logic start;
    logic beat_inc;
    logic frame_end;
    logic trunc_fire;

    eth_rr_select #(
        .N     (N_SRC),
        .IDX_W (IDX_W)
    ) u_rr_select (
        .req      (s_axis_tvalid),
        .last_idx (sel_q),
        .gnt      (rr_gnt),
        .idx      (rr_idx),
        .vld      (rr_vld)
    );

    assign src_tdata = s_axis_tdata[8*int'(sel_q) +: 8];
    assign src_valid = s_axis_tvalid[sel_q];
    assign src_last  = s_axis_tlast[sel_q];
    assign src_user  = s_axis_tuser[sel_q];
    // The beat that would make MAX_LEN without the source's own tlast is cut.
    assign trunc     = (beat_cnt == LAST_BEAT) && !src_last;

    assign grant    = grant_q;
    assign busy     = (state != IDLE);
    assign oversize = oversize_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and the pass-through / flush steering of the streams.
    always_comb begin
        state_nxt     = state;
        s_axis_tready = '0;
        m_axis_tdata  = 8'h00;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tuser  = 1'b0;
        start         = 1'b0;
        beat_inc      = 1'b0;
        frame_end     = 1'b0;
        trunc_fire    = 1'b0;
        case (state)
            IDLE: begin
                if (enable && rr_vld) begin
                    start     = 1'b1;
                    state_nxt = XFER;
                end
            end
            XFER: begin
                m_axis_tdata         = src_tdata;
                m_axis_tvalid        = src_valid;
                m_axis_tlast         = src_last | trunc;
                m_axis_tuser         = src_user | trunc;
                s_axis_tready[sel_q] = m_axis_tready;
                if (src_valid && m_axis_tready) begin
                    beat_inc = 1'b1;
                    if (src_last) begin
                        frame_end = 1'b1;
                        state_nxt = IDLE;
                    end else if (trunc) begin
                        trunc_fire = 1'b1;
                        state_nxt  = FLUSH;
                    end
                end
            end
            FLUSH: begin
                s_axis_tready[sel_q] = 1'b1;
                if (src_valid && src_last) begin
                    frame_end = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Owner, beat counter and the registered truncation pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q    <= '0;
            sel_q      <= IDX_W'(N_SRC - 1);
            beat_cnt   <= '0;
            oversize_q <= 1'b0;
        end else begin
            oversize_q <= trunc_fire;
            if (start) begin
                grant_q  <= rr_gnt;
                sel_q    <= rr_idx;
                beat_cnt <= '0;
            end else begin
                if (frame_end) begin
                    grant_q <= '0;
                end
                if (beat_inc) begin
                    beat_cnt <= beat_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_eth_tx_axis_arbiter.sv
// Bench for eth_tx_axis_arbiter: per-source beat queues drive the inputs,
// a scoreboard of expected output beats per source checks the MAC side.
module tb_eth_tx_axis_arbiter;

    localparam int N  = 4;
    localparam int ML = 100;
    localparam int LW = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             enable = 1'b0;
    logic [8*N-1:0]   s_axis_tdata = '0;
    logic [N-1:0]     s_axis_tvalid = '0;
    logic [N-1:0]     s_axis_tready;
    logic [N-1:0]     s_axis_tlast = '0;
    logic [N-1:0]     s_axis_tuser = '0;
    logic [7:0]       m_axis_tdata;
    logic             m_axis_tvalid;
    logic             m_axis_tready = 1'b0;
    logic             m_axis_tlast;
    logic             m_axis_tuser;
    logic [N-1:0]     grant;
    logic             busy;
    logic             oversize;

    always #5 clk = ~clk;

    eth_tx_axis_arbiter #(
        .N_SRC   (N),
        .MAX_LEN (ML),
        .LEN_W   (LW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tuser  (s_axis_tuser),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .grant         (grant),
        .busy          (busy),
        .oversize      (oversize)
    );

    typedef struct packed {
        logic [7:0] d;
        logic       l;
        logic       u;
    } beat_t;

    beat_t srcq [N][$];
    beat_t expq [N][$];
    int    out_src [$];

    int checks    = 0;
    int failures  = 0;
    int rdy_pct   = 100;
    int gap_pct   = 0;
    int out_beats = 0;
    int ovs_cnt   = 0;

    logic [N-1:0] hs_pend = '0;
    int           mon_owner;
    beat_t        mon_exp;

    // Source driver and MAC-side monitor: inputs change on the falling edge,
    // outputs are sampled 1 time unit later, well away from the rising edge.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (hs_pend[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
            end
            m_axis_tready = (int'($urandom_range(99)) < rdy_pct);
            for (int i = 0; i < N; i++) begin
                if (srcq[i].size() > 0 && !(gap_pct > 0 && int'($urandom_range(99)) < gap_pct)) begin
                    s_axis_tvalid[i]       = 1'b1;
                    s_axis_tdata[8*i +: 8] = srcq[i][0].d;
                    s_axis_tlast[i]        = srcq[i][0].l;
                    s_axis_tuser[i]        = srcq[i][0].u;
                end else begin
                    s_axis_tvalid[i]       = 1'b0;
                    s_axis_tdata[8*i +: 8] = 8'h00;
                    s_axis_tlast[i]        = 1'b0;
                    s_axis_tuser[i]        = 1'b0;
                end
            end
            #1;
            hs_pend = s_axis_tvalid & s_axis_tready;
            if (s_axis_tready != '0) begin
                checks++;
                if ((s_axis_tready & ~grant) != '0) begin
                    failures++;
                    $display("FAIL ready_ungranted: s_axis_tready=%b grant=%b", s_axis_tready, grant);
                end
            end
            if (oversize) ovs_cnt++;
            if (m_axis_tvalid && m_axis_tready) begin
                mon_owner = -1;
                for (int i = 0; i < N; i++) if (grant[i]) mon_owner = i;
                checks++;
                if (mon_owner < 0 || expq[mon_owner].size() == 0) begin
                    failures++;
                    $display("FAIL out_unexpected: grant=%b data=%h last=%b user=%b, required a queued beat",
                             grant, m_axis_tdata, m_axis_tlast, m_axis_tuser);
                end else begin
                    mon_exp = expq[mon_owner].pop_front();
                    if ({m_axis_tdata, m_axis_tlast, m_axis_tuser} !== mon_exp) begin
                        failures++;
                        $display("FAIL out_beat src%0d: got d=%h l=%b u=%b, required d=%h l=%b u=%b",
                                 mon_owner, m_axis_tdata, m_axis_tlast, m_axis_tuser,
                                 mon_exp.d, mon_exp.l, mon_exp.u);
                    end
                end
                out_beats++;
                if (m_axis_tlast) out_src.push_back(mon_owner);
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    function automatic bit all_empty();
        for (int i = 0; i < N; i++) begin
            if (srcq[i].size() != 0 || expq[i].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Queue one frame on a source and the beats the MAC should see from it.
    task automatic send_frame(input int src, input int len, input int base, input bit usr);
        beat_t b;
        beat_t e;
        for (int k = 0; k < len; k++) begin
            b.d = 8'(base + k * 7 + src * 31);
            b.l = (k == len - 1);
            b.u = usr;
            srcq[src].push_back(b);
            if (k < ML) begin
                e = b;
                if (len > ML && k == ML - 1) begin
                    e.l = 1'b1;
                    e.u = 1'b1;
                end
                expq[src].push_back(e);
            end
        end
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(posedge clk);
            #2;
            if (all_empty() && !busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (grant !== '0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_grant_busy: grant=%b busy=%b, required 0/0", grant, busy);
        end
        checks++;
        if (m_axis_tvalid !== 1'b0 || s_axis_tready !== '0 || oversize !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: m_tvalid=%b s_tready=%b oversize=%b, required 0",
                     m_axis_tvalid, s_axis_tready, oversize);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        enable = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (grant !== '0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_no_request: grant=%b busy=%b, required 0/0", grant, busy);
        end
    endtask

    task automatic test_single();
        bit ok;
        int b0;
        int c;
        b0 = out_beats;
        out_src.delete();
        send_frame(0, 64, 8'h10, 1'b0);
        for (c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (grant != '0) break;
        end
        checks++;
        if (grant !== 4'b0001 || m_axis_tvalid !== 1'b1) begin
            failures++;
            $display("FAIL single_grant: grant=%b m_tvalid=%b, required 0001/1", grant, m_axis_tvalid);
        end
        wait_idle(500, ok);
        checks++;
        if (!ok || grant !== '0) begin
            failures++;
            $display("FAIL single_done: idle=%0d grant=%b, required 1/0000", ok, grant);
        end
        checks++;
        if (out_beats - b0 != 64 || out_src.size() != 1) begin
            failures++;
            $display("FAIL single_count: beats=%0d frames=%0d, required 64/1", out_beats - b0, out_src.size());
        end
    endtask

    task automatic test_round_robin();
        bit ok;
        do_reset();
        out_src.delete();
        for (int f = 0; f < 3; f++) begin
            for (int s = 0; s < N; s++) send_frame(s, 5 + s + f, 16 * f, 1'b0);
        end
        wait_idle(2000, ok);
        checks++;
        if (!ok || out_src.size() != 12) begin
            failures++;
            $display("FAIL rr_frames: idle=%0d frames=%0d, required 1/12", ok, out_src.size());
        end else begin
            for (int k = 0; k < 12; k++) begin
                checks++;
                if (out_src[k] != k % N) begin
                    failures++;
                    $display("FAIL rr_order[%0d]: src=%0d, required %0d", k, out_src[k], k % N);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        out_src.delete();
        rdy_pct = 50;
        gap_pct = 30;
        for (int f = 0; f < 16; f++) begin
            send_frame(int'($urandom_range(N - 1)), 1 + int'($urandom_range(39)), f * 5, f[0]);
        end
        wait_idle(20000, ok);
        checks++;
        if (!ok || out_src.size() != 16) begin
            failures++;
            $display("FAIL bp_frames: idle=%0d frames=%0d, required 1/16", ok, out_src.size());
        end
        rdy_pct = 100;
        gap_pct = 0;
    endtask

    task automatic test_oversize();
        bit ok;
        int o0;
        int b0;
        do_reset();
        out_src.delete();
        o0 = ovs_cnt;
        b0 = out_beats;
        send_frame(2, 150, 8'h21, 1'b0);
        send_frame(3, 12, 8'h40, 1'b0);
        wait_idle(2000, ok);
        checks++;
        if (!ok || ovs_cnt - o0 != 1 || out_beats - b0 != 112) begin
            failures++;
            $display("FAIL oversize: idle=%0d pulses=%0d beats=%0d, required 1/1/112",
                     ok, ovs_cnt - o0, out_beats - b0);
        end
        checks++;
        if (out_src.size() != 2 || out_src[0] != 2 || out_src[1] != 3) begin
            failures++;
            $display("FAIL oversize_next: frames=%0d, required order 2,3", out_src.size());
        end
    endtask

    task automatic test_exact_len();
        bit ok;
        int o0;
        int b0;
        o0 = ovs_cnt;
        b0 = out_beats;
        send_frame(1, ML, 8'h55, 1'b0);
        send_frame(0, 20, 8'h66, 1'b1);
        wait_idle(2000, ok);
        checks++;
        if (!ok || ovs_cnt - o0 != 0 || out_beats - b0 != ML + 20) begin
            failures++;
            $display("FAIL exact_len: idle=%0d pulses=%0d beats=%0d, required 1/0/%0d",
                     ok, ovs_cnt - o0, out_beats - b0, ML + 20);
        end
    endtask

    task automatic test_enable();
        bit ok;
        int b0;
        out_src.delete();
        b0 = out_beats;
        send_frame(1, 64, 8'h70, 1'b0);
        for (int c = 0; c < 200 && out_beats - b0 < 10; c++) @(posedge clk);
        enable = 1'b0;
        send_frame(0, 8, 8'h90, 1'b0);
        ok = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(posedge clk);
            #2;
            if (expq[1].size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (!ok || out_beats - b0 != 64 || grant !== '0 || busy !== 1'b0 || expq[0].size() != 8) begin
            failures++;
            $display("FAIL enable_hold: done=%0d beats=%0d grant=%b busy=%b pending=%0d, required 1/64/0/0/8",
                     ok, out_beats - b0, grant, busy, expq[0].size());
        end
        enable = 1'b1;
        wait_idle(500, ok);
        checks++;
        if (!ok || out_src.size() != 2 || out_src[0] != 1 || out_src[1] != 0) begin
            failures++;
            $display("FAIL enable_resume: idle=%0d frames=%0d, required order 1,0", ok, out_src.size());
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int b0;
        b0 = out_beats;
        send_frame(2, 64, 8'hA0, 1'b0);
        for (int c = 0; c < 200 && out_beats - b0 < 5; c++) @(posedge clk);
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (m_axis_tvalid !== 1'b0 || grant !== '0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid: m_tvalid=%b grant=%b busy=%b, required 0/0/0",
                     m_axis_tvalid, grant, busy);
        end
        for (int i = 0; i < N; i++) begin
            srcq[i].delete();
            expq[i].delete();
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        out_src.delete();
        send_frame(3, 6, 8'hB0, 1'b0);
        send_frame(0, 6, 8'hC0, 1'b0);
        wait_idle(500, ok);
        checks++;
        if (!ok || out_src.size() != 2 || out_src[0] != 0 || out_src[1] != 3) begin
            failures++;
            $display("FAIL reset_first_win: idle=%0d frames=%0d, required order 0,3", ok, out_src.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_oversize();
        test_exact_len();
        test_enable();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
